// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// FSM state types and the address-to-register-index helper.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Byte address to word index; the sub-word byte offset is discarded.
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                  input int unsigned data_width);
        if (data_width == 32'd64) begin
            return addr >> 32'd3;
        end else begin
            return addr >> 32'd2;
        end
    endfunction

endpackage

// File: rtl/axi_lite_regbank.sv
// Register array with a byte-strobed write port, one combinational read port
// and a flat view of every register.
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [IDX_W-1:0]               widx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic [IDX_W-1:0]               ridx,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Next register contents: merge strobed bytes into the addressed word.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (widx == IDX_W'(i))) begin
                for (int b = 0; b < NB; b++) begin
                    if (wstrb[b]) begin
                        regs_d[i][b*8 +: 8] = wdata[b*8 +: 8];
                    end else begin
                        regs_d[i][b*8 +: 8] = regs_q[i][b*8 +: 8];
                    end
                end
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register storage, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read mux; sees the pre-write value when a write lands on the same edge.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = regs_q[i];
            end else begin
                rdata = rdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank with independent write and read channels.
// Build option AXIL_REGS_ERR_RESP_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXIL_REGS_ERR_RESP_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;

    r_state_e              r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s, we_s;
    logic [ADDR_WIDTH-1:0] c_addr_s;
    logic [DATA_WIDTH-1:0] c_data_s, bank_rdata_s;
    logic [STRB_W-1:0]     c_strb_s;
    logic [31:0]           wr_idx_s, rd_idx_s;
    logic                  wr_in_range_s, rd_in_range_s;

    assign AWREADY = !ARESET && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA));
    assign WREADY  = !ARESET && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR));
    assign ARREADY = !ARESET && (r_state_q == R_IDLE);
    assign BVALID  = (w_state_q == W_RESP);
    assign RVALID  = (r_state_q == R_DATA);
    assign BRESP   = bresp_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    assign aw_hs_s = AWVALID && AWREADY;
    assign w_hs_s  = WVALID && WREADY;
    assign ar_hs_s = ARVALID && ARREADY;

    // Commit payload: whichever half arrived earlier comes from its latch.
    always_comb begin
        c_addr_s = (w_state_q == W_HAVE_ADDR) ? awaddr_q : AWADDR;
        c_data_s = (w_state_q == W_HAVE_DATA) ? wdata_q  : WDATA;
        c_strb_s = (w_state_q == W_HAVE_DATA) ? wstrb_q  : WSTRB;
    end

    assign wr_idx_s      = addr_to_index(32'(c_addr_s), DATA_WIDTH);
    assign rd_idx_s      = addr_to_index(32'(ARADDR), DATA_WIDTH);
    assign wr_in_range_s = (wr_idx_s < 32'(NUM_REGS));
    assign rd_in_range_s = (rd_idx_s < 32'(NUM_REGS));
    assign we_s          = commit_s && wr_in_range_s;

    // Write channel FSM: collect AW and W in any order, commit, then respond.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        commit_s  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    commit_s  = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs_s) begin
                    awaddr_d  = AWADDR;
                    w_state_d = W_HAVE_ADDR;
                end else if (w_hs_s) begin
                    wdata_d   = WDATA;
                    wstrb_d   = WSTRB;
                    w_state_d = W_HAVE_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs_s) begin
                    commit_s  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_HAVE_ADDR;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs_s) begin
                    commit_s  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
        if (commit_s) begin
            bresp_d = wr_in_range_s ? RESP_OKAY : OOR_RESP;
        end else begin
            bresp_d = bresp_q;
        end
    end

    // Read channel FSM: capture data on the AR handshake, hold until RREADY.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rdata_d   = rd_in_range_s ? bank_rdata_s : '0;
                    rresp_d   = rd_in_range_s ? RESP_OKAY : OOR_RESP;
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Channel state and payload registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    axi_lite_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regbank (
        .clk    (ACLK),
        .rst    (ARESET),
        .we     (we_s),
        .widx   (wr_idx_s[IDX_W-1:0]),
        .wdata  (c_data_s),
        .wstrb  (c_strb_s),
        .ridx   (rd_idx_s[IDX_W-1:0]),
        .rdata  (bank_rdata_s),
        .regs_o (regs_o)
    );

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: drivers push expected B/R responses
// computed from a word-array model; a monitor pops them on each handshake.
module tb_axi_lite_slave_regs;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int SB = DW / 8;

`ifdef AXIL_REGS_ERR_RESP_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [AW-1:0]   AWADDR, ARADDR;
    logic            AWVALID, WVALID, ARVALID, BREADY, RREADY;
    logic            AWREADY, WREADY, ARREADY, BVALID, RVALID;
    logic [DW-1:0]   WDATA, RDATA;
    logic [SB-1:0]   WSTRB;
    logic [1:0]      BRESP, RRESP;
    logic [NR*DW-1:0] regs_o;

    axi_lite_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_o(regs_o)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic [1:0] resp; logic [NR*DW-1:0] regs; } b_exp_t;
    typedef struct { logic [1:0] resp; logic [DW-1:0] data; } r_exp_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [NR];
    b_exp_t      exp_b [$];
    r_exp_t      exp_r [$];
    b_exp_t      be;
    r_exp_t      re;
    bit          bready_hold = 1'b0;
    bit          rready_hold = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] flat_model();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
        return v;
    endfunction

    function automatic int word_of(input logic [AW-1:0] addr);
        return int'(addr) / SB;
    endfunction

    // Random ready generation; holds let a test stall a channel on purpose.
    always @(negedge ACLK) begin
        BREADY = bready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        RREADY = rready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every B/R handshake against the scoreboard.
    always @(negedge ACLK) begin
        #3;
        if (!ARESET) begin
            if (BVALID && BREADY) begin
                if (exp_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected: got BRESP %0h expected no response", BRESP);
                end else begin
                    be = exp_b.pop_front();
                    check("bresp", BRESP, be.resp);
                    check("regs_after_write", regs_o, be.regs);
                end
            end
            if (RVALID && RREADY) begin
                if (exp_r.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL r_unexpected: got RDATA %0h expected no response", RDATA);
                end else begin
                    re = exp_r.pop_front();
                    check("rresp", RRESP, re.resp);
                    check("rdata", RDATA, re.data);
                end
            end
        end
    end

    // mode 0: AW and W together; 1: AW first, W after gap; 2: W first, AW after gap.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SB-1:0] strb, input int mode, input int gap);
        bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs, fin;
        int aw_start = (mode == 2) ? gap : 0;
        int w_start  = (mode == 1) ? gap : 0;
        b_exp_t e;
        for (int cyc = 0; cyc < 80 && !(aw_done && w_done); cyc++) begin
            @(negedge ACLK);
            AWADDR  = addr;
            WDATA   = data;
            WSTRB   = strb;
            AWVALID = !aw_done && (cyc >= aw_start);
            WVALID  = !w_done && (cyc >= w_start);
            #3;
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            fin   = (aw_hs || aw_done) && (w_hs || w_done);
            @(posedge ACLK);
            aw_done |= aw_hs;
            w_done  |= w_hs;
            if (fin) begin
                if (word_of(addr) < NR) begin
                    for (int b = 0; b < SB; b++)
                        if (strb[b]) model[word_of(addr)][b*8 +: 8] = data[b*8 +: 8];
                    e.resp = 2'b00;
                end else begin
                    e.resp = OOR;
                end
                e.regs = flat_model();
                exp_b.push_back(e);
                #1;
                check("bvalid_latency", BVALID, 1'b1);
            end
        end
        @(negedge ACLK);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            checks++; failures++;
            $display("FAIL write_timeout: got aw=%0d w=%0d expected both handshakes", aw_done, w_done);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr);
        bit done = 1'b0, hs;
        r_exp_t e;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge ACLK);
            ARADDR  = addr;
            ARVALID = 1'b1;
            #3;
            hs = ARREADY;
            if (hs) begin
                e.data = (word_of(addr) < NR) ? model[word_of(addr)] : 32'h0;
                e.resp = (word_of(addr) < NR) ? 2'b00 : OOR;
                exp_r.push_back(e);
            end
            @(posedge ACLK);
            if (hs) begin
                done = 1'b1;
                #1;
                check("rvalid_latency", RVALID, 1'b1);
            end
        end
        @(negedge ACLK);
        ARVALID = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL read_timeout: got no AR handshake expected one");
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge ACLK);
            #4;
            ok = (exp_b.size() == 0) && (exp_r.size() == 0) && !BVALID && !RVALID;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got b=%0d r=%0d pending expected 0", exp_b.size(), exp_r.size());
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got no completion expected finish before 200us");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] bresp0;
        ARESET = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
        BREADY = 1'b0; RREADY = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;

        repeat (3) @(negedge ACLK);
        #3;
        check("rst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("rst_valids", {BVALID, RVALID}, 2'b00);
        check("rst_resps", {BRESP, RRESP}, 4'b0000);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_regs", regs_o, flat_model());
        @(negedge ACLK);
        ARESET = 1'b0;
        #3;
        check("post_rst_readies", {AWREADY, WREADY, ARREADY}, 3'b111);

        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        drain();
        check("reg1", regs_o[1*DW +: DW], 32'hDEADBEEF);

        do_write(8'h08, 32'h11223344, 4'h5, 2, 3);
        drain();
        check("reg2_strobe", regs_o[2*DW +: DW], 32'h00220044);

        bready_hold = 1'b1;
        do_write(8'h14, 32'hCAFEF00D, 4'hF, 1, 2);
        bresp0 = BRESP;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            #3;
            check("bp_bvalid", BVALID, 1'b1);
            check("bp_bresp", BRESP, bresp0);
            check("bp_readies", {AWREADY, WREADY}, 2'b00);
        end
        bready_hold = 1'b0;
        drain();
        check("bp_idle_readies", {AWREADY, WREADY}, 2'b11);

        do_write(8'h0C, 32'hA5A5A5A5, 4'hF, 0, 0);
        drain();
        rready_hold = 1'b1;
        fork
            do_write(8'h0C, 32'h00000001, 4'hF, 0, 0);
            do_read(8'h0C);
        join
        #3;
        check("same_cycle_rdata", RDATA, 32'hA5A5A5A5);
        rready_hold = 1'b0;
        drain();
        check("reg3_after", regs_o[3*DW +: DW], 32'h00000001);

        do_read(8'h40);
        do_write(8'h40, 32'h12345678, 4'hF, 0, 0);
        do_write(8'h10, 32'h87654321, 4'h0, 1, 1);
        drain();

        @(negedge ACLK);
        AWADDR = 8'h10; AWVALID = 1'b1;
        #3;
        check("mid_aw_ready", AWREADY, 1'b1);
        @(posedge ACLK);
        @(negedge ACLK);
        AWVALID = 1'b0;
        ARESET = 1'b1;
        #3;
        check("mid_rst_regs", regs_o, {(NR*DW){1'b0}});
        @(negedge ACLK);
        ARESET = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            #3;
            check("mid_no_bvalid", BVALID, 1'b0);
        end
        check("mid_back_idle", {AWREADY, WREADY}, 2'b11);
        do_write(8'h10, 32'h0BADF00D, 4'hF, 0, 0);
        drain();

        for (int it = 0; it < 60; it++) begin
            logic [AW-1:0] a;
            int op;
            a  = AW'($urandom_range(0, 32'h4F));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_write(a, $urandom, SB'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3));
            end else if (op == 1) begin
                do_read(a);
            end else begin
                fork
                    do_write(a, $urandom, SB'($urandom_range(0, 15)), 0, 0);
                    do_read(a);
                join
            end
        end
        drain();
        check("final_regs", regs_o, flat_model());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
